// File: rtl/sr_cmd_gen_pkg.sv
// sr_cmd_gen_pkg
//   Shared definitions for the SR command generator:
//   - state_t : command FSM states
//   - pend_t  : encoding of the one-deep pending request slot
//   - default parameter constants for debounce length and pulse length
package sr_cmd_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        RST_PULSE = 2'd2,
        GAP       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_SET  = 2'd1,
        PEND_RST  = 2'd2
    } pend_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PULSE_LEN       = 3;

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce
//   Two-flop synchronizer followed by a debouncer for one push-button.
//   The debounced level flips only after DEBOUNCE_CYCLES consecutive
//   synchronized samples disagree with it; any agreeing sample clears the run.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   raw   : asynchronous raw button input
//   level : debounced button level
module sr_debounce
    import sr_cmd_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This sample completes the stable run: accept the new level.
                // The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen
//   Turns two raw push-buttons into clean, non-overlapping S / R pulses for a
//   downstream SR flip-flop. Each debounced rising level is one request.
//   Requests arriving while a pulse is running are held in a one-deep slot;
//   a further request is dropped and flagged by overflow. Simultaneous set and
//   reset requests are both discarded and flagged by conflict.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   btn_set   : raw set button
//   btn_reset : raw reset button
//   S, R      : registered set / reset drive (never both high)
//   busy      : registered, high when the FSM is not IDLE
//   conflict  : one-cycle pulse, set and reset requests in the same cycle
//   overflow  : one-cycle pulse, a request was dropped (slot full)
//   dbg_state : current FSM state, for observation
//
// Handshake: none -- the buttons are free-running level inputs and the outputs
// are plain registered levels/pulses; there is no valid/ready pairing.
module sr_cmd_gen
    import sr_cmd_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_LEN       = DEF_PULSE_LEN
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   btn_set,
    input  logic   btn_reset,
    output logic   S,
    output logic   R,
    output logic   busy,
    output logic   conflict,
    output logic   overflow,
    output state_t dbg_state
);

    localparam int PW = $clog2(PULSE_LEN + 1);

    logic          level_set;
    logic          level_rst;
    logic          hist_set;
    logic          hist_rst;
    logic          set_req;
    logic          rst_req;
    logic          both_req;
    pend_t         new_req;
    state_t        state;
    pend_t         pend;
    logic [PW-1:0] pcnt;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_set),
        .level (level_set)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_reset),
        .level (level_rst)
    );

    assign set_req  = level_set & ~hist_set;
    assign rst_req  = level_rst & ~hist_rst;
    assign both_req = set_req & rst_req;

    // A single request only; a simultaneous pair cancels to nothing.
    always_comb begin
        new_req = PEND_NONE;
        if (set_req && !rst_req) begin
            new_req = PEND_SET;
        end else if (rst_req && !set_req) begin
            new_req = PEND_RST;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= PEND_NONE;
            pcnt     <= '0;
            hist_set <= 1'b0;
            hist_rst <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            overflow <= 1'b0;
        end else begin
            hist_set <= level_set;
            hist_rst <= level_rst;
            conflict <= both_req;
            overflow <= 1'b0;

            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (pend != PEND_NONE) begin
                        // Slot is consumed now; a request in this same cycle
                        // lands in the freshly emptied slot.
                        state <= (pend == PEND_SET) ? SET_PULSE : RST_PULSE;
                        S     <= (pend == PEND_SET);
                        R     <= (pend == PEND_RST);
                        busy  <= 1'b1;
                        pend  <= new_req;
                    end else if (new_req != PEND_NONE) begin
                        state <= (new_req == PEND_SET) ? SET_PULSE : RST_PULSE;
                        S     <= (new_req == PEND_SET);
                        R     <= (new_req == PEND_RST);
                        busy  <= 1'b1;
                    end
                end
                SET_PULSE, RST_PULSE: begin
                    if (pcnt == PW'(PULSE_LEN - 1)) begin
                        state <= GAP;
                        S     <= 1'b0;
                        R     <= 1'b0;
                        pcnt  <= '0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (state != IDLE && new_req != PEND_NONE) begin
                if (pend == PEND_NONE) begin
                    pend <= new_req;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen
//   Directed scenarios plus randomized button activity for sr_cmd_gen at
//   default parameters. A behavioural model tracks the expected outputs as a
//   "cycles left in the current command" countdown plus a one-entry pending
//   list, and every cycle's outputs are compared against it.
module tb_sr_cmd_gen;
    import sr_cmd_gen_pkg::*;

    localparam int D = DEF_DEBOUNCE_CYCLES;
    localparam int P = DEF_PULSE_LEN;

    // ---------------- clock / reset / DUT ----------------
    logic   clk;
    logic   rst_n;
    logic   btn_set;
    logic   btn_reset;
    logic   S;
    logic   R;
    logic   busy;
    logic   conflict;
    logic   overflow;
    state_t dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sr_cmd_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_set   (btn_set),
        .btn_reset (btn_reset),
        .S         (S),
        .R         (R),
        .busy      (busy),
        .conflict  (conflict),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // Per button: 2-stage sync pipe, accepted level, previous accepted level,
    // run length of samples disagreeing with the accepted level.
    bit m_s1[2];
    bit m_s2[2];
    bit m_deb[2];
    bit m_prev[2];
    int m_run[2];
    // Command: kind 1 = set, 2 = reset; m_left counts remaining busy cycles
    // (P pulse cycles + 1 gap cycle); 0 means idle.
    int m_kind;
    int m_left;
    int m_pend;
    bit m_conf;
    bit m_ovf;

    task automatic model_step(input bit rs, input bit rr, input bit rn);
        bit raw[2];
        bit req[2];
        int nk;
        raw[0] = rs;
        raw[1] = rr;
        if (!rn) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_prev[b] = 0; m_run[b] = 0;
            end
            m_kind = 0; m_left = 0; m_pend = 0; m_conf = 0; m_ovf = 0;
            return;
        end
        for (int b = 0; b < 2; b++) req[b] = m_deb[b] && !m_prev[b];
        m_conf = req[0] && req[1];
        nk = m_conf ? 0 : (req[0] ? 1 : (req[1] ? 2 : 0));
        m_ovf = 0;
        if (m_left == 0) begin
            if (m_pend != 0) begin
                m_kind = m_pend; m_left = P + 1; m_pend = nk;
            end else if (nk != 0) begin
                m_kind = nk; m_left = P + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (nk != 0) begin
                if (m_pend == 0) m_pend = nk;
                else m_ovf = 1;
            end
        end
        for (int b = 0; b < 2; b++) begin
            m_prev[b] = m_deb[b];
            if (m_s2[b] == m_deb[b]) m_run[b] = 0;
            else if (m_run[b] + 1 >= D) begin m_deb[b] = m_s2[b]; m_run[b] = 0; end
            else m_run[b] = m_run[b] + 1;
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    function automatic state_t exp_state();
        if (m_left == 0) return IDLE;
        if (m_left == 1) return GAP;
        return (m_kind == 1) ? SET_PULSE : RST_PULSE;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit s, input bit r, input bit rn);
        btn_set   = s;
        btn_reset = r;
        rst_n     = rn;
        @(posedge clk);
        model_step(s, r, rn);
        #1;
        check("S",         32'(S),         32'(m_kind == 1 && m_left > 1));
        check("R",         32'(R),         32'(m_kind == 2 && m_left > 1));
        check("busy",      32'(busy),      32'(m_left > 0));
        check("conflict",  32'(conflict),  32'(m_conf));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("dbg_state", 32'(dbg_state), 32'(exp_state()));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    // Bit i of each pattern is the input level captured at step i; bit i of
    // each trace is the output observed just after that edge.
    logic [31:0] s_tr, r_tr, b_tr, c_tr, o_tr, i_tr;

    task automatic run_trace(input int n, input logic [31:0] sp, input logic [31:0] rp,
                             input logic [31:0] np);
        s_tr = '0; r_tr = '0; b_tr = '0; c_tr = '0; o_tr = '0; i_tr = '0;
        for (int i = 0; i < n; i++) begin
            step(sp[i], rp[i], np[i]);
            s_tr[i] = S;
            r_tr[i] = R;
            b_tr[i] = busy;
            c_tr[i] = conflict;
            o_tr[i] = overflow;
            i_tr[i] = (dbg_state == IDLE);
        end
    endtask

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    // ---------------- stimulus ----------------
    initial begin
        btn_set = 1'b0; btn_reset = 1'b0; rst_n = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("reset_outputs", {27'd0, S, R, busy, conflict, overflow}, 32'd0);
        idle_steps(5);

        // Set held: S high after edges 6..8, busy through the gap, no R
        run_trace(12, ONES, 32'h0, ONES);
        check("set_S_trace",    s_tr, 32'h0000_01C0);
        check("set_R_trace",    r_tr, 32'h0);
        check("set_busy_trace", b_tr, 32'h0000_03C0);
        idle_steps(15);

        // Three-cycle reset glitch is rejected
        run_trace(14, 32'h0, 32'h0000_0007, ONES);
        check("glitch_R_trace",    r_tr, 32'h0);
        check("glitch_busy_trace", b_tr, 32'h0);
        idle_steps(10);

        // Simultaneous presses: one conflict pulse, nothing else
        run_trace(12, ONES, ONES, ONES);
        check("conf_trace",      c_tr, 32'h0000_0040);
        check("conf_S_trace",    s_tr, 32'h0);
        check("conf_R_trace",    r_tr, 32'h0);
        check("conf_idle_trace", i_tr, 32'h0000_0FFF);
        idle_steps(15);

        // Reset request during set pulse: S, gap, idle, then R
        run_trace(17, ONES, 32'hFFFF_FFFE, ONES);
        check("seq_S_trace",    s_tr, 32'h0000_01C0);
        check("seq_R_trace",    r_tr, 32'h0000_3800);
        check("seq_busy_trace", b_tr, 32'h0000_7BC0);
        idle_steps(15);

        // Pending reset plus second set request while busy: overflow,
        // only the pending R pulse follows the set pulse
        run_trace(22, 32'hFFFF_FE1E, 32'hFFFF_FF0F, ONES);
        check("ovf_trace",   o_tr, 32'h0000_8000);
        check("ovf_S_trace", s_tr, 32'h0000_3800);
        check("ovf_R_trace", r_tr, 32'h0007_01C0);
        check("ovf_conf",    c_tr, 32'h0);
        idle_steps(20);

        // Reset during R pulse: R drops at that edge, nothing follows
        run_trace(24, 32'h0, 32'h0000_007F, 32'hFFFF_FE7F);
        check("rstmid_R_trace",    r_tr, 32'h0000_0040);
        check("rstmid_busy_trace", b_tr, 32'h0000_0040);
        check("rstmid_S_trace",    s_tr, 32'h0);
        idle_steps(5);

        // Button held through reset release: exactly one set pulse
        run_trace(20, ONES, 32'h0, 32'hFFFF_FFF8);
        check("heldrst_S_trace",    s_tr, 32'h0000_0E00);
        check("heldrst_busy_trace", b_tr, 32'h0000_1E00);
        idle_steps(15);

        // Randomized button activity against the model
        for (int seg = 0; seg < 160; seg++) begin
            bit s_lvl;
            bit r_lvl;
            bit rn_lvl;
            int len;
            s_lvl  = 1'($urandom_range(0, 1));
            r_lvl  = 1'($urandom_range(0, 1));
            rn_lvl = ($urandom_range(0, 30) != 0);
            len    = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) step(s_lvl, r_lvl, rn_lvl);
        end
        idle_steps(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples needed to accept a button level change (legal range 1..255).
REQ-002 Parameter PULSE_LEN, default 3, is the number of cycles S or R is held high per accepted command (legal range 1..255).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port btn_set, input, 1 bit: raw asynchronous set push-button, active-high.
REQ-006 Port btn_reset, input, 1 bit: raw asynchronous reset push-button, active-high.
REQ-007 Port S, output, 1 bit: registered set drive to the downstream SR flip-flop S input.
REQ-008 Port R, output, 1 bit: registered reset drive to the downstream SR flip-flop R input.
REQ-009 Port busy, output, 1 bit: registered; high whenever the FSM is not in IDLE.
REQ-010 Port conflict, output, 1 bit: registered one-cycle pulse when set and reset edges are accepted in the same cycle.
REQ-011 Port overflow, output, 1 bit: registered one-cycle pulse when a request is dropped because the pending slot is full.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that flips its output only after DEBOUNCE_CYCLES consecutive edges with the synchronized value differing from the debounced level.
REQ-013 The debounce counter SHALL clear on any edge where the synchronized value equals the debounced level, so glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
REQ-014 A request SHALL be the 0->1 transition of a debounced level; 1->0 transitions and held levels SHALL NOT generate requests.
REQ-015 Latency: for a raw rise captured at edge k and held stable, the output (S or R) SHALL go high from edge k+DEBOUNCE_CYCLES+2 when the FSM is IDLE, which is k+6 at default parameters.
REQ-016 FSM states SHALL be IDLE, SET_PULSE, RST_PULSE and GAP.
REQ-017 FSM transitions SHALL be:
- IDLE -> SET_PULSE on a set request, or on a pending set.
- IDLE -> RST_PULSE on a reset request, or on a pending reset.
- SET_PULSE/RST_PULSE -> GAP after PULSE_LEN cycles.
- GAP -> IDLE after exactly one cycle.
REQ-018 S SHALL be high only in SET_PULSE and R only in RST_PULSE, so S and R are never both high and are both low for at least one cycle between pulses.
REQ-019 Simultaneous set and reset requests in the same cycle SHALL both be discarded, pulse conflict for one cycle, and leave the state and the pending slot unchanged.
REQ-020 A single request arriving while the FSM is not in IDLE SHALL be stored in a one-deep pending slot if the slot is empty, or dropped with an overflow pulse if the slot is full.
REQ-021 On entering IDLE from GAP with the pending slot full, the FSM SHALL consume the slot in that same IDLE cycle and enter the matching pulse state on the next edge.
REQ-022 A new request arriving in IDLE while the pending slot is full (same cycle it is consumed) SHALL be treated as arriving while busy (REQ-020 applies after consumption).
REQ-023 Counter widths SHALL be $clog2(param+1) bits; counters SHALL saturate, never wrap.

Reset
REQ-024 With rst_n low at a clock edge, the following SHALL clear to 0 at that edge: S, R, busy, conflict, overflow, the synchronizers, the debounced levels, the edge-detect history, all counters and the pending slot; the FSM SHALL return to IDLE.
REQ-025 Reset asserted mid-pulse SHALL drop S/R low at that edge and discard any pending request.
REQ-026 A button held high through reset release SHALL generate exactly one request after the debounce latency.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration, the pending-slot encoding (NONE/SET/RST) and the default parameter constants.
REQ-028 Synchronizer plus debouncer SHALL be one sub-module, sr_debounce, instantiated once per button.

Verification
REQ-029 The bench SHALL cover these directed scenarios (default parameters):
- btn_set raised and held from edge k -> S high during edges k+6..k+8, busy high, R stays 0.
- btn_reset 3-cycle glitch -> no R pulse, busy stays 0.
- btn_set and btn_reset raised in the same cycle -> conflict pulses once, S=R=0, FSM stays IDLE.
- Set pulse in progress, then reset request -> S pulse completes, one GAP cycle, one IDLE cycle, then R high for 3 cycles.
- Set in progress with a pending reset, then a second set request -> overflow pulses once, only the pending R pulse follows.
- rst_n low during R pulse -> R 0 at that edge, no later pulse, all outputs 0.
